// File: rtl/prgm_sequencer.sv
// Host-side sequencer for the computer programming port: one command at a time,
// fixed SETUP/STROBE/HOLD timing. Optional write read-back check: VERIFY_WRITE_EN.
module prgm_sequencer #(
  parameter int         SETUP_CYC = 2,
  parameter int         HOLD_CYC  = 1,
  parameter logic [3:0] ALU_SEL   = 4'b0011
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_kind,
  input  logic [3:0] i_cmd_sel,
  input  logic [7:0] i_cmd_data,
  input  logic [2:0] i_cmd_op,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [7:0] o_rsp_data,
  input  logic       i_halt_req,
  input  logic [7:0] i_bus_out,
  output logic [3:0] o_sel,
  output logic [7:0] o_prgm_in,
  output logic [2:0] o_op_prgm,
  output logic       o_prgm,
  output logic       o_go,
  output logic       o_oe,
  output logic       o_en,
  output logic       o_we,
  output logic       o_hlt
`ifdef VERIFY_WRITE_EN
  ,
  output logic       o_wr_err
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RESP} state_t;
  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_ALU = 2'd1;
  localparam logic [1:0] K_RD  = 2'd2;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_kind, w_kind_nxt;
  logic [3:0] r_sel, w_sel_nxt;
  logic [7:0] r_prgm_in, w_prgm_in_nxt;
  logic [2:0] r_op, w_op_nxt;
  logic       r_prgm, w_prgm_nxt, r_go, w_go_nxt, r_oe, w_oe_nxt;
  logic       r_en, w_en_nxt, r_we, w_we_nxt, r_hlt;
  logic       r_cmd_ready, w_cmd_ready_nxt, r_rsp_valid, w_rsp_valid_nxt;
  logic [7:0] r_rsp_data, w_rsp_data_nxt;
  logic       w_done;
`ifdef VERIFY_WRITE_EN
  logic [7:0] r_data, w_data_nxt;
  logic       r_vfy, w_vfy_nxt, r_wr_err, w_wr_err_nxt;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_kind      <= K_WR;
      r_sel       <= '0;
      r_prgm_in   <= '0;
      r_op        <= '0;
      r_prgm      <= 1'b0;
      r_go        <= 1'b0;
      r_oe        <= 1'b0;
      r_en        <= 1'b0;
      r_we        <= 1'b0;
      r_hlt       <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
`ifdef VERIFY_WRITE_EN
      r_data      <= '0;
      r_vfy       <= 1'b0;
      r_wr_err    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_kind      <= w_kind_nxt;
      r_sel       <= w_sel_nxt;
      r_prgm_in   <= w_prgm_in_nxt;
      r_op        <= w_op_nxt;
      r_prgm      <= w_prgm_nxt;
      r_go        <= w_go_nxt;
      r_oe        <= w_oe_nxt;
      r_en        <= w_en_nxt;
      r_we        <= w_we_nxt;
      r_hlt       <= i_halt_req;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
`ifdef VERIFY_WRITE_EN
      r_data      <= w_data_nxt;
      r_vfy       <= w_vfy_nxt;
      r_wr_err    <= w_wr_err_nxt;
`endif
    end
  end

  // Sample point: end of the last HOLD cycle, or of STROBE when there is no HOLD.
  assign w_done = (r_state == S_STROBE && HOLD_CYC == 0) ||
                  (r_state == S_HOLD && r_cnt == 4'd0);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_kind_nxt      = r_kind;
    w_sel_nxt       = r_sel;
    w_prgm_in_nxt   = r_prgm_in;
    w_op_nxt        = r_op;
    w_prgm_nxt      = r_prgm;
    w_go_nxt        = r_go;
    w_oe_nxt        = r_oe;
    w_en_nxt        = r_en;
    w_we_nxt        = r_we;
    w_cmd_ready_nxt = r_cmd_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
`ifdef VERIFY_WRITE_EN
    w_data_nxt      = r_data;
    w_vfy_nxt       = r_vfy;
    w_wr_err_nxt    = r_wr_err;
`endif
    case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (i_cmd_valid && r_cmd_ready) begin
          w_cmd_ready_nxt = 1'b0;
          w_state_nxt     = S_SETUP;
          w_cnt_nxt       = 4'(SETUP_CYC - 1);
`ifdef VERIFY_WRITE_EN
          w_data_nxt      = i_cmd_data;
          w_vfy_nxt       = 1'b0;
`endif
          case (i_cmd_kind)
            2'b00: begin
              w_kind_nxt    = K_WR;
              w_sel_nxt     = i_cmd_sel;
              w_prgm_in_nxt = i_cmd_data;
              w_prgm_nxt    = 1'b1;
              w_we_nxt      = 1'b1;
            end
            2'b01: begin
              w_kind_nxt = K_ALU;
              w_sel_nxt  = ALU_SEL;
              w_op_nxt   = i_cmd_op;
              w_oe_nxt   = 1'b1;
            end
            default: begin
              w_kind_nxt = K_RD;
              w_sel_nxt  = i_cmd_sel;
              w_prgm_nxt = 1'b0;
              w_en_nxt   = 1'b1;
            end
          endcase
        end
      end
      S_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_STROBE;
          w_go_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_STROBE: begin
        w_go_nxt = 1'b0;
        if (HOLD_CYC != 0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = 4'(HOLD_CYC - 1);
        end
      end
      S_HOLD: begin
        if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
`ifdef VERIFY_WRITE_EN
          w_wr_err_nxt    = 1'b0;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_done) begin
      if (r_kind == K_WR) begin
        w_prgm_nxt = 1'b0;
        w_we_nxt   = 1'b0;
`ifdef VERIFY_WRITE_EN
        // Chain a read of the same SEL through the full timing sequence.
        w_kind_nxt  = K_RD;
        w_en_nxt    = 1'b1;
        w_vfy_nxt   = 1'b1;
        w_state_nxt = S_SETUP;
        w_cnt_nxt   = 4'(SETUP_CYC - 1);
`else
        w_state_nxt     = S_IDLE;
        w_cmd_ready_nxt = 1'b1;
`endif
      end else begin
        w_oe_nxt        = 1'b0;
        w_en_nxt        = 1'b0;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_data_nxt  = i_bus_out;
        w_state_nxt     = S_RESP;
`ifdef VERIFY_WRITE_EN
        w_wr_err_nxt    = r_vfy && (i_bus_out != r_data);
`endif
      end
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_sel       = r_sel;
  assign o_prgm_in   = r_prgm_in;
  assign o_op_prgm   = r_op;
  assign o_prgm      = r_prgm;
  assign o_go        = r_go;
  assign o_oe        = r_oe;
  assign o_en        = r_en;
  assign o_we        = r_we;
  assign o_hlt       = r_hlt;
`ifdef VERIFY_WRITE_EN
  assign o_wr_err    = r_wr_err;
`endif

endmodule
